// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU operation codes and sequencer state encoding
package alu_pkg;

    localparam logic [1:0] OP_TRANSFER = 2'b00;
    localparam logic [1:0] OP_ADD      = 2'b01;
    localparam logic [1:0] OP_SUB_AB   = 2'b10;
    localparam logic [1:0] OP_SUB_BA   = 2'b11;

    localparam logic MODE_ARITH = 1'b1;
    localparam logic MODE_LOGIC = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_slice_mux.sv
// rtl/alu_slice_mux.sv - maps the registered wide command and slice index onto the N-bit ALU ports
module alu_slice_mux
    import alu_pkg::*;
#(
    parameter int W  = 16,
    parameter int N  = 4,
    parameter int IW = $clog2(W / N + 1)
) (
    input  logic          i_active,
    input  logic [IW-1:0] i_idx,
    input  logic [W-1:0]  i_a,
    input  logic [W-1:0]  i_b,
    input  logic          i_cin,
    input  logic [1:0]    i_oper,
    input  logic          i_mode,
    input  logic          i_alu_cout,
    output logic [N-1:0]  o_alu_a,
    output logic [N-1:0]  o_alu_b,
    output logic          o_alu_cin,
    output logic [1:0]    o_alu_oper,
    output logic          o_alu_mode
);

    localparam int S = W / N;

    logic [N-1:0] w_ai;
    logic [N-1:0] w_bi;
    logic         w_first;

    assign w_first = (i_idx == '0);

    always_comb begin
        w_ai = '0;
        w_bi = '0;
        for (int i = 0; i < S; i++) begin
            if (i_idx == IW'(i)) begin
                w_ai = i_a[i*N +: N];
                w_bi = i_b[i*N +: N];
            end
        end
    end

    // Subtractions start with the ALU's native subtract on slice 0 and
    // continue as ADD with the subtrahend inverted and the carry chained.
    always_comb begin
        o_alu_a    = '0;
        o_alu_b    = '0;
        o_alu_cin  = 1'b0;
        o_alu_oper = OP_TRANSFER;
        o_alu_mode = MODE_LOGIC;
        if (i_active) begin
            o_alu_a    = w_ai;
            o_alu_b    = w_bi;
            o_alu_oper = i_oper;
            o_alu_mode = i_mode;
            if (i_mode == MODE_ARITH) begin
                case (i_oper)
                    OP_ADD: begin
                        o_alu_cin = w_first ? i_cin : i_alu_cout;
                    end
                    OP_SUB_AB: begin
                        if (!w_first) begin
                            o_alu_oper = OP_ADD;
                            o_alu_b    = ~w_bi;
                            o_alu_cin  = i_alu_cout;
                        end
                    end
                    OP_SUB_BA: begin
                        if (!w_first) begin
                            o_alu_oper = OP_ADD;
                            o_alu_a    = ~w_ai;
                            o_alu_cin  = i_alu_cout;
                        end
                    end
                    default: o_alu_cin = 1'b0;
                endcase
            end
        end
    end

endmodule

// File: rtl/alu_wide_sequencer.sv
// rtl/alu_wide_sequencer.sv - splits a W-bit command into LSB-first N-bit ALU slices and reassembles the result
module alu_wide_sequencer
    import alu_pkg::*;
#(
    parameter int W = 16,
    parameter int N = 4
) (
    input  logic         Clk,
    input  logic         rst_n,
    input  logic         i_cmd_valid,
    output logic         o_cmd_ready,
    input  logic [W-1:0] i_cmd_a,
    input  logic [W-1:0] i_cmd_b,
    input  logic         i_cmd_cin,
    input  logic [1:0]   i_cmd_oper,
    input  logic         i_cmd_mode,
    output logic         o_rsp_valid,
    input  logic         i_rsp_ready,
    output logic [W-1:0] o_rsp_sum,
    output logic         o_rsp_cout,
    output logic [N-1:0] o_alu_a,
    output logic [N-1:0] o_alu_b,
    output logic         o_alu_cin,
    output logic [1:0]   o_alu_oper,
    output logic         o_alu_mode,
    input  logic [N-1:0] i_alu_sum,
    input  logic         i_alu_cout
);

    localparam int S  = W / N;
    localparam int IW = $clog2(S + 1);

    state_t        r_state;
    logic [IW-1:0] r_idx;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic          r_cin;
    logic [1:0]    r_oper;
    logic          r_mode;
    logic [W-1:0]  r_rsp_sum;
    logic          r_rsp_cout;

    logic          w_last;
    logic          w_active;
    logic          w_keep_cout;

    assign w_last      = (r_idx == IW'(S));
    assign w_active    = (r_state == RUN) && !w_last;
    assign w_keep_cout = (r_mode == MODE_ARITH) && (r_oper != OP_TRANSFER);

    // Gated by rst_n so the initiator sees no readiness while held in reset.
    assign o_cmd_ready = (r_state == IDLE) && rst_n;
    assign o_rsp_valid = (r_state == DONE);
    assign o_rsp_sum   = r_rsp_sum;
    assign o_rsp_cout  = r_rsp_cout;

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_cin      <= 1'b0;
            r_oper     <= OP_TRANSFER;
            r_mode     <= MODE_LOGIC;
            r_rsp_sum  <= '0;
            r_rsp_cout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        r_a     <= i_cmd_a;
                        r_b     <= i_cmd_b;
                        r_cin   <= i_cmd_cin;
                        r_oper  <= i_cmd_oper;
                        r_mode  <= i_cmd_mode;
                        r_idx   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    // The ALU result of slice k-1 is visible during cycle k.
                    for (int i = 1; i <= S; i++) begin
                        if (r_idx == IW'(i)) begin
                            r_rsp_sum[(i-1)*N +: N] <= i_alu_sum;
                        end
                    end
                    if (w_last) begin
                        r_rsp_cout <= w_keep_cout ? i_alu_cout : 1'b0;
                        r_state    <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (i_rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    alu_slice_mux #(
        .W  (W),
        .N  (N),
        .IW (IW)
    ) u_slice_mux (
        .i_active   (w_active),
        .i_idx      (r_idx),
        .i_a        (r_a),
        .i_b        (r_b),
        .i_cin      (r_cin),
        .i_oper     (r_oper),
        .i_mode     (r_mode),
        .i_alu_cout (i_alu_cout),
        .o_alu_a    (o_alu_a),
        .o_alu_b    (o_alu_b),
        .o_alu_cin  (o_alu_cin),
        .o_alu_oper (o_alu_oper),
        .o_alu_mode (o_alu_mode)
    );

endmodule

// File: doc/alu_wide_sequencer.md
# alu_wide_sequencer

Command-side initiator for the registered N-bit ALU. It accepts one W-bit arithmetic or logic command over a valid/ready handshake and splits it into W/N slice operations. Slices are issued to the ALU LSB first, with the ALU carry-out chained into the next slice. The block assembles the W-bit result and returns it over a second valid/ready handshake. It sits between the datapath controller and the ALU instance, so the ALU can serve wider operands without any change to the ALU itself.

## Interface
- W, 16, command operand width; must be a multiple of N
- N, 4, ALU slice width; must match the ALU's N
- S (localparam), W/N, slice count
- Clk  in  1  clock, posedge
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  block accepts command
- cmd_a / cmd_b  in  W  operands
- cmd_cin  in  1  carry-in, used by ADD only
- cmd_oper  in  2  operation code; ALU encoding
- cmd_mode  in  1  1 = arithmetic, 0 = logic
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer accepts result
- rsp_sum  out  W  result
- rsp_cout  out  1  final carry; 0 for TRANSFER and logic ops
- alu_a / alu_b  out  N  slice operands to ALU
- alu_cin / alu_oper / alu_mode  out  1/2/1  slice controls to ALU
- alu_sum / alu_cout  in  N/1  registered ALU outputs

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: cmd_ready=1.
  - On cmd_valid&&cmd_ready, the command is registered, idx=0, and the FSM goes to RUN.
- RUN, cycle with index k (0..S):
  - If k<S, drive slice k on the ALU ports.
  - If k≥1, capture alu_sum into rsp_sum[(k-1)*N +: N] at the end of the cycle.
  - At k==S, also capture alu_cout into rsp_cout (forced to 0 for TRANSFER and logic ops), then go to DONE.
- DONE: rsp_valid=1; rsp_sum and rsp_cout are held stable. On rsp_ready the FSM goes to IDLE.
- Slice mapping (i = slice index; Ai/Bi = operand slices; c = alu_cout):
  - TRANSFER (mode1, oper00): oper 00, A=Ai, cin 0.
  - ADD (mode1, oper01): oper 01, A=Ai, B=Bi. cin is cmd_cin for i=0, c for i>0.
  - SUB A-B (mode1, oper10):
    - i=0: oper 10, A=A0, B=B0, cin 0.
    - i>0: oper 01, A=Ai, B=~Bi, cin c.
    - rsp_cout=1 means no borrow. cmd_cin is ignored.
  - SUB B-A (mode1, oper11):
    - i=0: oper 11, A=A0, B=B0, cin 0.
    - i>0: oper 01, A=~Ai, B=Bi, cin c.
    - cmd_cin is ignored.
  - Logic (mode0): oper=cmd_oper, A=Ai, B=Bi, cin 0. alu_cout is ignored; the ALU holds Cout in logic mode.
- alu_cin for chained slices comes combinationally from alu_cout, the registered ALU output of the previous slice.
- Outside RUN, and at k==S: alu_a=0, alu_b=0, alu_cin=0, alu_oper=00, alu_mode=0.
- Reset values: cmd_ready=0 while rst_n is low and 1 in IDLE after release. rsp_valid=0, rsp_sum=0, rsp_cout=0, all alu_* outputs 0, state IDLE.
- Reset mid-RUN or mid-DONE: the operation is abandoned and no response is issued. The ALU shares rst_n.
- cmd_valid while not in IDLE: cmd_ready=0, command not taken. The block is single-outstanding.

## Timing
- Accept edge E0; slice k is driven in cycle [Ek, Ek+1), and the ALU samples it at Ek+1.
- rsp_valid rises after edge ES+1, i.e. S+1 cycles after accept (5 for the defaults).
- When rsp_ready=1 at the first DONE cycle, cmd_ready reasserts one cycle later. Minimum command period is S+3 cycles.
- rsp_ready low: DONE is held indefinitely and outputs do not change.

## Structure
- Shared package alu_pkg holds:
  - oper codes OP_TRANSFER/OP_ADD/OP_SUB_AB/OP_SUB_BA (2'b00..11) and MODE_ARITH/MODE_LOGIC;
  - the state enum {IDLE, RUN, DONE}.
- One sub-module, alu_slice_mux, is natural. It is combinational and maps (command, idx, alu_cout) to the alu_* ports. The FSM, counter, and result register stay in the top.

## Test plan
- ADD 0xFFFF+0x0001, cin0 -> rsp_sum 0x0000, rsp_cout 1, rsp_valid 5 cycles after accept.
- ADD 0x1234+0x0FFF, cin1 -> 0x2234, cout 0. Also check alu_cin equals the previous alu_cout on slices 1..3.
- SUB A-B 0x1000-0x0001 -> 0x0FFF, cout 1. SUB B-A with A=0x0005, B=0x0003 -> 0xFFFE, cout 0.
- Logic XOR 0xA5A5, 0xFFFF, issued right after an ADD with carry -> 0x5A5A, cout 0.
- rsp_ready low for 3 cycles with cmd_valid held high -> rsp_sum held stable, cmd_ready 0, second command accepted only after the response handshake.
- rst_n pulsed low during RUN (k=2) -> all outputs 0 immediately, no rsp_valid. A new command after reset completes correctly.
